// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i memory-port arbiter slice.
//   owner_t     : which requester owns the response returning next cycle
//   MEM_LATENCY : cycles from address to read data at the memory port
package rv32i_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned MEM_LATENCY = 1;

endpackage : rv32i_pkg

// File: rtl/rv32i_arbFairness.sv
// Starvation guard for the fetch requester.
// Counts consecutive cycles in which fetch asked for the memory and lost.
// Once the count reaches STARVE_MAX, force_if tells the arbiter to let
// fetch win regardless of a pending data request.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   if_req   : fetch is requesting this cycle
//   if_gnt   : fetch was granted this cycle
//   force_if : fetch must win this cycle
module rv32i_arbFairness #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg;

  // A cycle without a fetch request also clears the count, so the
  // "consecutive losses" window restarts whenever fetch goes quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= 4'd0;
    end else if (!if_req || if_gnt) begin
      starve_cnt_reg <= 4'd0;
    end else if (starve_cnt_reg < MAX_CNT) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  assign force_if = (starve_cnt_reg == MAX_CNT);

endmodule : rv32i_arbFairness

// File: rtl/rv32i_memarbiter.sv
// Arbiter for the single-ported instruction/data memory.
// Grants at most one of fetch / data per cycle (data first, fetch forced
// through after STARVE_MAX consecutive losses), drives the shared memory
// port and routes the registered read data back to its owner next cycle.
//   clk, reset (async active-low)
//   fetch side : if_req, if_addr -> if_gnt, if_rdata, if_rvalid
//   data side  : d_req, d_we, d_be, d_addr, d_wdata -> d_gnt, d_rdata, d_rvalid
//   memory     : mem_addr, mem_we, mem_be, mem_wdata -> mem_rdata
//   stall_if   : fetch is requesting but was not granted
module rv32i_memarbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic [29:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if
);

  logic        force_if;
  owner_t      grant_own;
  owner_t      resp_sel_reg;
  owner_t      resp_sel_next;
  logic [29:0] last_addr_reg;

  rv32i_arbFairness #(
    .STARVE_MAX(STARVE_MAX)
  ) u_fairness (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );

  // Data has priority unless the starvation guard hands the cycle to fetch.
  always_comb begin
    grant_own = OWN_NONE;
    if (d_req && !(if_req && force_if)) begin
      grant_own = OWN_D;
    end else if (if_req) begin
      grant_own = OWN_IF;
    end
  end

  assign if_gnt   = (grant_own == OWN_IF);
  assign d_gnt    = (grant_own == OWN_D);
  assign stall_if = if_req && !if_gnt;

  // Memory port mux. With no grant the address is parked on the last
  // granted value so the memory sees no spurious address toggling.
  always_comb begin
    mem_addr  = last_addr_reg;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_wdata = d_wdata;
    if (grant_own == OWN_IF) begin
      mem_addr = if_addr;
    end else if (grant_own == OWN_D) begin
      mem_addr = d_addr;
      mem_we   = d_we;
      if (d_we) begin
        mem_be = d_be;
      end
    end
  end

  // Writes produce no response, so only read grants claim the return slot.
  always_comb begin
    resp_sel_next = OWN_NONE;
    if (grant_own == OWN_IF) begin
      resp_sel_next = OWN_IF;
    end else if (grant_own == OWN_D && !d_we) begin
      resp_sel_next = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_sel_reg  <= OWN_NONE;
      last_addr_reg <= 30'd0;
    end else begin
      resp_sel_reg <= resp_sel_next;
      if (grant_own != OWN_NONE) begin
        last_addr_reg <= mem_addr;
      end
    end
  end

  assign if_rvalid = (resp_sel_reg == OWN_IF);
  assign d_rvalid  = (resp_sel_reg == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule : rv32i_memarbiter

// File: tb/tb_rv32i_memarbiter.sv
module tb_rv32i_memarbiter;
  import rv32i_pkg::*;

  localparam int unsigned SM = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        stall_if;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    owner_t      own;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mem[64];
  logic [31:0] ref_mem[64];
  logic [3:0]  m_cnt = '0;
  logic [29:0] m_last = '0;
  logic        m_last_ok = 1'b0;

  rv32i_memarbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  always #5 clk = ~clk;

  // Registered single-port memory: data for the address seen at an edge
  // appears right after that edge.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[5:0]];
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic ireq, input logic [29:0] iaddr,
                      input logic dreq, input logic dwe, input logic [3:0] dbe,
                      input logic [29:0] daddr, input logic [31:0] dwdata,
                      output logic got_if);
    resp_t       r;
    logic        e_if;
    logic        e_d;
    logic [29:0] a;
    @(posedge clk); #1;
    if_req = ireq; if_addr = iaddr;
    d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwdata;
    @(negedge clk);
    r.own = OWN_NONE; r.data = '0;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    check_val("if_rvalid", 32'(if_rvalid), 32'(r.own == OWN_IF));
    check_val("d_rvalid", 32'(d_rvalid), 32'(r.own == OWN_D));
    if (r.own == OWN_IF) check_val("if_rdata", if_rdata, r.data);
    if (r.own == OWN_D)  check_val("d_rdata", d_rdata, r.data);
    e_if = ireq && (!dreq || m_cnt == 4'(SM));
    e_d  = dreq && !e_if;
    check_val("if_gnt", 32'(if_gnt), 32'(e_if));
    check_val("d_gnt", 32'(d_gnt), 32'(e_d));
    check_val("stall_if", 32'(stall_if), 32'(ireq && !e_if));
    check_val("mem_we", 32'(mem_we), 32'(e_d && dwe));
    if (e_if || e_d) begin
      a = e_if ? iaddr : daddr;
      m_last = a; m_last_ok = 1'b1;
      check_val("mem_be", 32'(mem_be), 32'((e_d && dwe) ? dbe : 4'hF));
    end
    if (m_last_ok) check_val("mem_addr", 32'(mem_addr), 32'(m_last));
    if (e_d && dwe) begin
      check_val("mem_wdata", mem_wdata, dwdata);
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[daddr[5:0]][8*b +: 8] = dwdata[8*b +: 8];
    end
    if (e_if) exp_q.push_back('{OWN_IF, ref_mem[iaddr[5:0]]});
    else if (e_d && !dwe) exp_q.push_back('{OWN_D, ref_mem[daddr[5:0]]});
    if (!ireq || e_if) m_cnt = '0;
    else if (m_cnt < 4'(SM)) m_cnt = m_cnt + 4'd1;
    $display("[TB] t=%0t ireq=%0d ia=%h dreq=%0d we=%0d da=%h -> ig=%0d dg=%0d",
             $time, ireq, iaddr, dreq, dwe, daddr, if_gnt, d_gnt);
    got_if = e_if;
  endtask

  task automatic idle();
    logic g;
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, g);
  endtask

  initial begin
    logic        g;
    logic [29:0] fa;
    logic [29:0] da;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = (32'(i) * 32'h01010101) ^ 32'hA5C30000;
      ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5C30000;
    end

    // Reset state
    @(negedge clk); @(negedge clk);
    check_val("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_val("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Fetch only, addresses 0,1,2
    for (int i = 0; i < 3; i++) step(1'b1, 30'(i), 1'b0, 1'b0, '0, '0, '0, g);
    idle(); idle();

    // Data read 0x10 against fetch 0x20, then fetch alone
    step(1'b1, 30'h20, 1'b1, 1'b0, 4'hF, 30'h10, '0, g);
    step(1'b1, 30'h20, 1'b0, 1'b0, '0, '0, '0, g);
    idle(); idle();

    // Continuous writes with fetch requesting: 3 data, 1 fetch, repeating
    fa = 30'h00; da = 30'h30;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, fa, 1'b1, 1'b1, 4'b0011, da, 32'hBEEF0000 | 32'(i), g);
      check_val("starve_pattern", 32'(g), 32'((i % 4) == 3));
      if (g) fa = fa + 30'd1;
      else   da = da + 30'd1;
    end
    idle();
    // Read back the partially written words
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 4'hF, 30'h30 + 30'(i), '0, g);
    idle();

    // Reset while a read response is in flight, with starvation built up
    step(1'b1, 30'h05, 1'b1, 1'b0, 4'hF, 30'h11, '0, g);
    step(1'b1, 30'h05, 1'b1, 1'b0, 4'hF, 30'h12, '0, g);
    reset_n = 1'b0;
    exp_q.delete();
    m_cnt = '0; m_last_ok = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    idle(); idle();
    @(posedge clk); #1 reset_n = 1'b1;
    // From idle: data wins three times before fetch is forced
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 30'h06, 1'b1, 1'b0, 4'hF, 30'h13, '0, g);
      check_val("post_rst_pattern", 32'(g), 32'(i == 3));
    end
    idle(); idle();

    // Alternating single requesters
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b1, 30'(i), 1'b0, 1'b0, '0, '0, '0, g);
      else            step(1'b0, '0, 1'b1, 1'b0, 4'hF, 30'h18 + 30'(i), '0, g);
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rv32i_memarbiter

// File: doc/rv32i_memarbiter.md
# rv32i_memArbiter

Arbitrates the single-ported instruction/data memory between the fetch stage (instruction requester) and the memory stage (data requester). Each cycle it grants at most one request, drives the shared memory port, and routes the registered read data back to the owner one cycle later. Data accesses have priority. A bounded starvation counter guarantees fetch forward progress. It sits between the fetch/memory stages and the memory interface, and produces the fetch stall.

## Interface
- STARVE_MAX, 3: consecutive cycles fetch may lose to data before fetch is forced to win (1..15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch requests a read this cycle.
- if_addr  in  30  fetch word address [31:2].
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rdata  out  32  instruction word, valid with if_rvalid.
- if_rvalid  out  1  fetch read data valid (registered).
- d_req  in  1  data request this cycle.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  write byte enables.
- d_addr  in  30  data word address [31:2].
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rdata  out  32  load data, valid with d_rvalid.
- d_rvalid  out  1  load data valid (registered; reads only).
- mem_addr  out  30  to memory interface.
- mem_we  out  1  memory write strobe.
- mem_be  out  4  memory byte enables (4'hF on reads).
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, registered in memory, one cycle after address.
- stall_if  out  1  if_req && !if_gnt.

## Operation
- Grant decision is combinational from the requests and the starvation count:
  - Only d_req asserted: data wins.
  - Only if_req asserted: fetch wins.
  - Both asserted, starve_cnt < STARVE_MAX: data wins.
  - Both asserted, starve_cnt == STARVE_MAX: fetch wins.
  - Neither asserted: no grant, mem_we = 0, mem_addr holds the last value.
- Memory port muxing:
  - Fetch owner: mem_addr = if_addr, mem_we = 0, mem_be = 4'hF.
  - Data owner: mem_addr/mem_we/mem_be/mem_wdata = d_* signals.
  - mem_we is never asserted without d_gnt.
- starve_cnt (4 bits):
  - Cleared on reset, on any fetch grant, and on any cycle with if_req = 0.
  - Increments when if_req is asserted and denied; saturates at STARVE_MAX.
- Response routing via the resp_sel register (OWN_NONE/OWN_IF/OWN_D), loaded each cycle:
  - OWN_IF on a fetch grant.
  - OWN_D on a data read grant.
  - OWN_NONE on a data write or no grant.
- Next cycle outputs:
  - if_rvalid = (resp_sel == OWN_IF); d_rvalid = (resp_sel == OWN_D).
  - if_rdata and d_rdata both carry mem_rdata and are meaningful only with their rvalid.
- Writes complete at the grant edge; no acknowledge beyond d_gnt.
- A requester must hold req/addr/data stable until its gnt is sampled high.

## Timing
- Reset (async assert): resp_sel = OWN_NONE, starve_cnt = 0, both rvalid = 0.
  - Combinational outputs follow their inputs.
  - A response in flight at reset is dropped and never presented.
- Read latency: grant in cycle N gives rvalid in cycle N+1. Back-to-back grants give back-to-back rvalids with no bubble.
- Fairness bound: with data requesting continuously, fetch is granted at most every STARVE_MAX+1 cycles.
- Simultaneous read grant and response: the new grant overwrites resp_sel at the same edge the previous response is presented. No conflict occurs.
- Deassertion of reset is synchronous to clk (synchronized upstream).

## Structure
- Shared package rv32i_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_IF, OWN_D}.
  - Constant MEM_LATENCY = 1.
- One sub-module, rv32i_arbFairness: holds starve_cnt, takes if_req, if_gnt and STARVE_MAX, and outputs force_if.
- The grant mux and resp_sel register stay in the top module.

## Test plan
- Fetch only, if_addr = 0,1,2 on consecutive cycles:
  - if_gnt = 1 every cycle.
  - if_rvalid high from cycle 1, with mem_rdata of each address in order.
  - d_rvalid = 0 throughout.
- Data read 0x10 and fetch 0x20 in the same cycle (starve_cnt = 0):
  - d_gnt = 1, stall_if = 1, mem_addr = 0x10.
  - Next cycle d_rvalid = 1; fetch is granted at 0x20.
- Data write (d_be = 4'b0011) continuously with fetch requesting, STARVE_MAX = 3:
  - Pattern is three data grants, then one fetch grant, repeating.
  - mem_we = 0 in every fetch-grant cycle.
- Reset asserted the cycle after a read grant:
  - rvalid stays 0, starve_cnt = 0, resp_sel = OWN_NONE.
  - After release, the first grant behaves as from idle.
- Alternating d_req and if_req, one per cycle: each is granted immediately and rvalids alternate with no gaps; starve_cnt stays 0.
